// File: rtl/issue_queue.sv
// Out-of-order ALU issue queue: holds renamed ops, snoops writeback tags for
// operand wakeup, and issues the oldest ready op over a valid/ready handshake.

`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif

package nand_cpu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NAND = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_PASS = 4'd9
  } AluOp;
endpackage

module issue_queue
  import nand_cpu_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_WAKEUP = 2,
  parameter int unsigned D_REG_W    = $clog2(`NUM_D_REG),
  parameter int unsigned S_REG_W    = $clog2(`NUM_S_REG),
  parameter int unsigned ROB_W      = 5
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROB_W-1:0]              in_rob_addr,
  input  AluOp                          in_alu_op,
  input  logic [5:0]                    in_immdt,
  input  logic                          in_use_ra,
  input  logic                          in_use_rt,
  input  logic [D_REG_W-1:0]            in_ra_addr,
  input  logic [D_REG_W-1:0]            in_rt_addr,
  input  logic                          in_ra_ready,
  input  logic                          in_rt_ready,
  input  logic                          in_write_dst,
  input  logic [D_REG_W-1:0]            in_rw_addr,
  input  logic [D_REG_W-1:0]            in_prev_rw_addr,
  input  logic [S_REG_W-1:0]            in_rs_addr,
  input  logic [S_REG_W-1:0]            in_prev_rs_addr,
  input  logic [NUM_WAKEUP-1:0]         wb_valid,
  input  logic [NUM_WAKEUP*D_REG_W-1:0] wb_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROB_W-1:0]              out_rob_addr,
  output AluOp                          out_alu_op,
  output logic [5:0]                    out_immdt,
  output logic                          out_use_ra,
  output logic [D_REG_W-1:0]            out_ra_addr,
  output logic                          out_use_rt,
  output logic [D_REG_W-1:0]            out_rt_addr,
  output logic                          out_write_dst,
  output logic [D_REG_W-1:0]            out_rw_addr,
  output logic [D_REG_W-1:0]            out_prev_rw_addr,
  output logic [S_REG_W-1:0]            out_rs_addr,
  output logic [S_REG_W-1:0]            out_prev_rs_addr,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ROB_W-1:0]   rob_addr;
    AluOp               alu_op;
    logic [5:0]         immdt;
    logic               use_ra;
    logic [D_REG_W-1:0] ra_addr;
    logic               use_rt;
    logic [D_REG_W-1:0] rt_addr;
    logic               write_dst;
    logic [D_REG_W-1:0] rw_addr;
    logic [D_REG_W-1:0] prev_rw_addr;
    logic [S_REG_W-1:0] rs_addr;
    logic [S_REG_W-1:0] prev_rs_addr;
  } entry_t;

  entry_t             r_pay   [DEPTH];
  logic [DEPTH-1:0]   r_older [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_ra_rdy;
  logic [DEPTH-1:0]   r_rt_rdy;
  logic [CNT_W-1:0]   r_count;
  logic               r_hold_vld;
  logic [IDX_W-1:0]   r_hold_idx;

  logic [DEPTH-1:0]   w_ready;
  logic [DEPTH-1:0]   w_ra_hit;
  logic [DEPTH-1:0]   w_rt_hit;
  logic               w_in_ra_hit;
  logic               w_in_rt_hit;
  logic               w_sel_vld;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_disp;
  logic               w_issue;
  entry_t             w_in_pay;
  entry_t             w_out;

  function automatic logic wb_hit(input logic [D_REG_W-1:0]            tag,
                                  input logic [NUM_WAKEUP-1:0]         vld,
                                  input logic [NUM_WAKEUP*D_REG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WAKEUP; p++) begin
      if (vld[p] && (tags[p*D_REG_W +: D_REG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-entry readiness and tag snoop, from registered state only.
  always_comb begin
    w_ready  = '0;
    w_ra_hit = '0;
    w_rt_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i]  = r_valid[i] & (~r_pay[i].use_ra | r_ra_rdy[i])
                               & (~r_pay[i].use_rt | r_rt_rdy[i]);
      w_ra_hit[i] = wb_hit(r_pay[i].ra_addr, wb_valid, wb_tag);
      w_rt_hit[i] = wb_hit(r_pay[i].rt_addr, wb_valid, wb_tag);
    end
    w_in_ra_hit = wb_hit(in_ra_addr, wb_valid, wb_tag);
    w_in_rt_hit = wb_hit(in_rt_addr, wb_valid, wb_tag);
  end

  // Oldest-ready select; a stalled choice is held so the payload stays stable.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    if (r_hold_vld && w_ready[r_hold_idx]) begin
      w_sel_vld = 1'b1;
      w_sel_idx = r_hold_idx;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ready[i] && ((r_older[i] & w_ready) == '0)) begin
          w_sel_vld = 1'b1;
          w_sel_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign in_ready = ~&r_valid;
  assign w_disp   = in_valid & in_ready & ~flush;
  assign w_issue  = w_sel_vld & out_ready & ~flush;

  assign w_in_pay = '{rob_addr: in_rob_addr, alu_op: in_alu_op, immdt: in_immdt,
                      use_ra: in_use_ra, ra_addr: in_ra_addr,
                      use_rt: in_use_rt, rt_addr: in_rt_addr,
                      write_dst: in_write_dst, rw_addr: in_rw_addr,
                      prev_rw_addr: in_prev_rw_addr, rs_addr: in_rs_addr,
                      prev_rs_addr: in_prev_rs_addr};

  assign w_out            = w_sel_vld ? r_pay[w_sel_idx] : '0;
  assign out_valid        = w_sel_vld;
  assign out_rob_addr     = w_out.rob_addr;
  assign out_alu_op       = w_out.alu_op;
  assign out_immdt        = w_out.immdt;
  assign out_use_ra       = w_out.use_ra;
  assign out_ra_addr      = w_out.ra_addr;
  assign out_use_rt       = w_out.use_rt;
  assign out_rt_addr      = w_out.rt_addr;
  assign out_write_dst    = w_out.write_dst;
  assign out_rw_addr      = w_out.rw_addr;
  assign out_prev_rw_addr = w_out.prev_rw_addr;
  assign out_rs_addr      = w_out.rs_addr;
  assign out_prev_rs_addr = w_out.prev_rs_addr;
  assign count            = r_count;

  // Entry state, age matrix and occupancy; flush overrides everything else.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid    <= '0;
      r_ra_rdy   <= '0;
      r_rt_rdy   <= '0;
      r_count    <= '0;
      r_hold_vld <= 1'b0;
      r_hold_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= '0;
        r_pay[i]   <= '0;
      end
    end else if (flush) begin
      r_valid    <= '0;
      r_count    <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_ra_rdy   <= r_ra_rdy | (w_ra_hit & r_valid);
      r_rt_rdy   <= r_rt_rdy | (w_rt_hit & r_valid);
      r_hold_vld <= w_sel_vld & ~out_ready;
      r_hold_idx <= w_sel_idx;
      r_count    <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
      if (w_issue) r_valid[w_sel_idx] <= 1'b0;
      if (w_disp) begin
        r_valid[w_free_idx]  <= 1'b1;
        r_pay[w_free_idx]    <= w_in_pay;
        r_ra_rdy[w_free_idx] <= in_ra_ready | w_in_ra_hit;
        r_rt_rdy[w_free_idx] <= in_rt_ready | w_in_rt_hit;
        r_older[w_free_idx]  <= r_valid;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != int'(w_free_idx)) r_older[j][w_free_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: vector table for single-cycle behaviour plus
// sequences for payload, full queue, refill ordering and async reset.

module tb_issue_queue;
  import nand_cpu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NW    = 2;
  localparam int unsigned DW    = 6;
  localparam int unsigned SW    = 4;
  localparam int unsigned RW    = 5;

  logic clk = 1'b0;
  logic n_rst, flush, in_valid, in_ready;
  logic [RW-1:0] in_rob_addr, out_rob_addr;
  AluOp in_alu_op, out_alu_op;
  logic [5:0] in_immdt, out_immdt;
  logic in_use_ra, in_use_rt, in_ra_ready, in_rt_ready, in_write_dst;
  logic [DW-1:0] in_ra_addr, in_rt_addr, in_rw_addr, in_prev_rw_addr;
  logic [SW-1:0] in_rs_addr, in_prev_rs_addr;
  logic [NW-1:0] wb_valid;
  logic [NW*DW-1:0] wb_tag;
  logic out_valid, out_ready, out_use_ra, out_use_rt, out_write_dst;
  logic [DW-1:0] out_ra_addr, out_rt_addr, out_rw_addr, out_prev_rw_addr;
  logic [SW-1:0] out_rs_addr, out_prev_rs_addr;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .D_REG_W(DW), .S_REG_W(SW), .ROB_W(RW)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rob_addr(in_rob_addr), .in_alu_op(in_alu_op), .in_immdt(in_immdt),
    .in_use_ra(in_use_ra), .in_use_rt(in_use_rt), .in_ra_addr(in_ra_addr),
    .in_rt_addr(in_rt_addr), .in_ra_ready(in_ra_ready), .in_rt_ready(in_rt_ready),
    .in_write_dst(in_write_dst), .in_rw_addr(in_rw_addr), .in_prev_rw_addr(in_prev_rw_addr),
    .in_rs_addr(in_rs_addr), .in_prev_rs_addr(in_prev_rs_addr),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_addr(out_rob_addr), .out_alu_op(out_alu_op), .out_immdt(out_immdt),
    .out_use_ra(out_use_ra), .out_ra_addr(out_ra_addr), .out_use_rt(out_use_rt),
    .out_rt_addr(out_rt_addr), .out_write_dst(out_write_dst), .out_rw_addr(out_rw_addr),
    .out_prev_rw_addr(out_prev_rw_addr), .out_rs_addr(out_rs_addr),
    .out_prev_rs_addr(out_prev_rs_addr), .count(count)
  );

  typedef struct {
    logic          iv;
    logic [RW-1:0] rob;
    logic          use_ra;
    logic [DW-1:0] ra;
    logic          ra_rdy;
    logic          use_rt;
    logic [DW-1:0] rt;
    logic          rt_rdy;
    logic [NW-1:0] wbv;
    logic [DW-1:0] wb0;
    logic [DW-1:0] wb1;
    logic          ordy;
    logic          fl;
    logic [3:0]    e_cnt;
    logic          e_ov;
    logic          e_ir;
    logic [RW-1:0] e_rob;
    logic [DW-1:0] e_ra;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [RW-1:0] rob, input logic use_ra,
                     input logic [DW-1:0] ra, input logic ra_rdy, input logic use_rt,
                     input logic [DW-1:0] rt, input logic rt_rdy);
    in_valid        = iv;
    in_rob_addr     = rob;
    in_alu_op       = ALU_ADD;
    in_immdt        = 6'd0;
    in_use_ra       = use_ra;
    in_ra_addr      = ra;
    in_ra_ready     = ra_rdy;
    in_use_rt       = use_rt;
    in_rt_addr      = rt;
    in_rt_ready     = rt_rdy;
    in_write_dst    = 1'b0;
    in_rw_addr      = '0;
    in_prev_rw_addr = '0;
    in_rs_addr      = '0;
    in_prev_rs_addr = '0;
  endtask

  function automatic vec_t mk(input logic iv, input int rob, input logic use_ra, input int ra,
                              input logic ra_rdy, input logic use_rt, input int rt,
                              input logic rt_rdy, input logic [1:0] wbv, input int wb0,
                              input int wb1, input logic ordy, input logic fl,
                              input int e_cnt, input logic e_ov, input logic e_ir,
                              input int e_rob, input int e_ra);
    vec_t v;
    v.iv = iv; v.rob = RW'(rob); v.use_ra = use_ra; v.ra = DW'(ra); v.ra_rdy = ra_rdy;
    v.use_rt = use_rt; v.rt = DW'(rt); v.rt_rdy = rt_rdy; v.wbv = wbv;
    v.wb0 = DW'(wb0); v.wb1 = DW'(wb1); v.ordy = ordy; v.fl = fl;
    v.e_cnt = 4'(e_cnt); v.e_ov = e_ov; v.e_ir = e_ir; v.e_rob = RW'(e_rob); v.e_ra = DW'(e_ra);
    return v;
  endfunction

  int exp_order [8];

  initial begin
    // iv rob ua ra rr ut rt tr wbv wb0 wb1 ordy fl | cnt ov ir rob ra
    vt[0]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 2'b00,  0,  0, 1, 0, 1, 0, 1, 0, 0);
    vt[1]  = mk(1, 2, 1, 7, 1, 0, 0, 0, 2'b00,  0,  0, 1, 0, 2, 1, 1, 2, 7);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01,  5,  0, 1, 0, 1, 1, 1, 1, 5);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 0, 1, 0, 0);
    vt[4]  = mk(1, 3, 0, 0, 0, 1, 9, 0, 2'b10,  0,  9, 0, 0, 1, 1, 1, 3, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 0, 1, 0, 0);
    vt[6]  = mk(1, 4, 1,10, 0, 0, 0, 0, 2'b01, 11,  0, 1, 0, 1, 0, 1, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10,  0, 10, 1, 0, 1, 1, 1, 4, 10);
    vt[8]  = mk(1, 6, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 0, 0, 2, 1, 1, 4, 10);
    vt[9]  = mk(1, 7, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 1, 0, 2, 1, 1, 6, 0);
    vt[10] = mk(1, 9, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 0, 0, 3, 1, 1, 6, 0);
    vt[11] = mk(1,10, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 0, 0, 4, 1, 1, 6, 0);
    vt[12] = mk(1,11, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 1, 1, 0, 0, 1, 0, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 0, 1, 0, 0);

    n_rst = 1'b0; flush = 1'b0; out_ready = 1'b0; wb_valid = '0; wb_tag = '0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_rob", 32'(out_rob_addr), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    cyc();

    for (int k = 0; k < 14; k++) begin
      drv(vt[k].iv, vt[k].rob, vt[k].use_ra, vt[k].ra, vt[k].ra_rdy,
          vt[k].use_rt, vt[k].rt, vt[k].rt_rdy);
      wb_valid  = vt[k].wbv;
      wb_tag    = {vt[k].wb1, vt[k].wb0};
      out_ready = vt[k].ordy;
      flush     = vt[k].fl;
      cyc();
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(vt[k].e_cnt));
      chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vt[k].e_ov));
      chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vt[k].e_ir));
      chk($sformatf("vec%0d_out_rob", k), 32'(out_rob_addr), 32'(vt[k].e_rob));
      chk($sformatf("vec%0d_out_ra", k), 32'(out_ra_addr), 32'(vt[k].e_ra));
    end
    flush = 1'b0; wb_valid = '0; drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Full payload round-trip.
    out_ready = 1'b0;
    drv(1, 21, 1, 33, 1, 1, 44, 1);
    in_alu_op = ALU_XOR; in_immdt = 6'h2A; in_write_dst = 1'b1;
    in_rw_addr = 6'd55; in_prev_rw_addr = 6'd56; in_rs_addr = 4'd9; in_prev_rs_addr = 4'd14;
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pay_valid", 32'(out_valid), 32'd1);
    chk("pay_rob", 32'(out_rob_addr), 32'd21);
    chk("pay_alu", 32'(out_alu_op), 32'(ALU_XOR));
    chk("pay_immdt", 32'(out_immdt), 32'h2A);
    chk("pay_use_ra", 32'(out_use_ra), 32'd1);
    chk("pay_ra", 32'(out_ra_addr), 32'd33);
    chk("pay_use_rt", 32'(out_use_rt), 32'd1);
    chk("pay_rt", 32'(out_rt_addr), 32'd44);
    chk("pay_wdst", 32'(out_write_dst), 32'd1);
    chk("pay_rw", 32'(out_rw_addr), 32'd55);
    chk("pay_prev_rw", 32'(out_prev_rw_addr), 32'd56);
    chk("pay_rs", 32'(out_rs_addr), 32'd9);
    chk("pay_prev_rs", 32'(out_prev_rs_addr), 32'd14);
    cyc();
    chk("pay_stall_rob", 32'(out_rob_addr), 32'd21);
    out_ready = 1'b1;
    cyc();
    chk("pay_drained", 32'(count), 32'd0);

    // Fill to capacity, refuse a ninth op, then drain in dispatch order.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1, RW'(i), 0, 0, 0, 0, 0, 0);
      cyc();
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drv(1, 20, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("full_ignored_count", 32'(count), 32'd8);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_rob", i), 32'(out_rob_addr), 32'(i));
      cyc();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Full queue, only entry 2 ready: issue it with a refused dispatch, refill it.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1, RW'(10 + i), 1, 20, (i == 2), 0, 0, 0);
      cyc();
    end
    chk("refill_sel_valid", 32'(out_valid), 32'd1);
    chk("refill_sel_rob", 32'(out_rob_addr), 32'd12);
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    drv(1, 30, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    cyc();
    chk("refill_refused_count", 32'(count), 32'd7);
    chk("refill_in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd20};
    cyc();
    chk("refill_count", 32'(count), 32'd8);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    wb_valid = '0;
    out_ready = 1'b1;
    exp_order = '{10, 11, 13, 14, 15, 16, 17, 30};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("refill%0d_rob", i), 32'(out_rob_addr), 32'(exp_order[i]));
      cyc();
    end
    chk("refill_drained", 32'(count), 32'd0);

    // Asynchronous reset with three entries live.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1, RW'(i + 1), 0, 0, 0, 0, 0, 0);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    cyc();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
